// File: rtl/palette_pkg.sv
// Shared types and constants for the palette arbiter slice.
// No ports: imported by the interface, the arbiter and the bench.
package palette_pkg;

    localparam int PAL_IDX_W = 8;
    localparam int RGB_W     = 24;

    typedef logic [PAL_IDX_W-1:0] pal_idx_t;
    typedef logic [RGB_W-1:0]     rgb_t;

    // Index reserved as "transparent"; the palette ROM maps it to the colour key.
    localparam pal_idx_t TRANSP_IDX = 8'h00;
    localparam rgb_t     TRANSP_RGB = 24'h800080;

endpackage

// File: rtl/palette_arbiter_if.sv
// Bundles the requester side, the external palette ROM hookup and the
// result handshake of palette_arbiter.
//   slave  : view of the arbiter (drives gnt, pal_index and the result)
//   master : view of the environment (drives requests, pal_rgb, out_ready)
interface palette_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    import palette_pkg::*;

    logic [N_REQ-1:0]           req;
    logic [PAL_IDX_W*N_REQ-1:0] req_index;
    logic [N_REQ-1:0]           gnt;
    pal_idx_t                   pal_index;
    rgb_t                       pal_rgb;
    logic                       out_valid;
    logic                       out_ready;
    logic [ID_W-1:0]            out_id;
    rgb_t                       out_rgb;
    logic                       out_transp;

    modport slave (
        input  req, req_index, pal_rgb, out_ready,
        output gnt, pal_index, out_valid, out_id, out_rgb, out_transp
    );

    modport master (
        output req, req_index, pal_rgb, out_ready,
        input  gnt, pal_index, out_valid, out_id, out_rgb, out_transp
    );

endinterface

// File: rtl/palette_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   en_i  : grants allowed this cycle
//   req_i : request vector
//   ptr_i : last granted ID; the search starts at ptr_i+1 and wraps mod N
//   gnt_o : one-hot grant (all zero when disabled or no request)
//   id_o  : encoded ID of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            en_i,
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [ID_W-1:0] id_o
);

    // Search upward from ptr_i+1; the first set request wins.
    always_comb begin
        logic            found_s;
        logic [ID_W-1:0] cand_s;
        gnt_o   = '0;
        id_o    = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 1; k <= N; k++) begin
            cand_s = ID_W'((int'(ptr_i) + k) % N);
            if (en_i && !found_s && req_i[cand_s]) begin
                gnt_o[cand_s] = 1'b1;
                id_o          = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/palette_arbiter.sv
// Round-robin sharing of one external combinational palette among N_REQ
// requesters, with a two-stage pipeline:
//   stage 1 registers {id, index} and drives pal_index to the palette ROM,
//   stage 2 captures pal_rgb with the requester ID and a transparency flag.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : palette_arbiter_if.slave (requests/grants, palette, result)
module palette_arbiter
    import palette_pkg::*;
#(
    parameter int       N_REQ      = 4,
    parameter int       ID_W       = $clog2(N_REQ),
    parameter pal_idx_t TRANSP_IDX = palette_pkg::TRANSP_IDX
) (
    input  logic               clk_i,
    input  logic               rst_i,
    palette_arbiter_if.slave   bus
);

    logic             adv1_s;
    logic             adv2_s;
    logic [N_REQ-1:0] gnt_s;
    logic [ID_W-1:0]  gnt_id_s;
    logic             gnt_any_s;

    logic             s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]  s1_id_q,    s1_id_d;
    pal_idx_t         s1_idx_q,   s1_idx_d;
    logic [ID_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [ID_W-1:0]  out_id_q,    out_id_d;
    rgb_t             out_rgb_q,   out_rgb_d;
    logic             out_transp_q, out_transp_d;

    // A stage may load when it is empty or its content moves on this cycle.
    assign adv2_s    = ~out_valid_q | bus.out_ready;
    assign adv1_s    = ~s1_valid_q | adv2_s;
    assign gnt_any_s = |gnt_s;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .en_i  (adv1_s),
        .req_i (bus.req),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_s),
        .id_o  (gnt_id_s)
    );

    // Next-state for the index stage and the round-robin pointer.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_idx_d   = s1_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (adv1_s) begin
            if (gnt_any_s) begin
                s1_valid_d = 1'b1;
                s1_id_d    = gnt_id_s;
                s1_idx_d   = bus.req_index[int'(gnt_id_s)*PAL_IDX_W +: PAL_IDX_W];
                rr_ptr_d   = gnt_id_s;
            end else begin
                // pal_index keeps its last value; only the valid bit drops.
                s1_valid_d = 1'b0;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Next-state for the result stage; everything holds under backpressure.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_id_d     = out_id_q;
        out_rgb_d    = out_rgb_q;
        out_transp_d = out_transp_q;
        if (adv2_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_rgb_d    = bus.pal_rgb;
                out_id_d     = s1_id_q;
                out_transp_d = (s1_idx_q == TRANSP_IDX);
            end else begin
                out_rgb_d = out_rgb_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline and pointer registers; the pointer resets to N_REQ-1 so
    // requester 0 is first in line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            s1_idx_q     <= '0;
            rr_ptr_q     <= ID_W'(N_REQ - 1);
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_rgb_q    <= '0;
            out_transp_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_idx_q     <= s1_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_rgb_q    <= out_rgb_d;
            out_transp_q <= out_transp_d;
        end
    end

    assign bus.gnt        = gnt_s;
    assign bus.pal_index  = s1_idx_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_rgb    = out_rgb_q;
    assign bus.out_transp = out_transp_q;

endmodule

// File: tb/tb_palette_arbiter.sv
// Scoreboard bench for palette_arbiter: stimulus pushes expected results,
// a forked monitor pops and compares whenever a result is accepted.
module tb_palette_arbiter;
    import palette_pkg::*;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        rgb_t            rgb;
        logic            transp;
    } res_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    res_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    palette_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    palette_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // External palette ROM model.
    function automatic rgb_t pal_model(input pal_idx_t idx);
        case (idx)
            8'h00:   return 24'h800080;
            8'h01:   return 24'h000000;
            8'h02:   return 24'he6e6e6;
            8'h03:   return 24'h505050;
            8'h14:   return 24'h260939;
            default: return 24'h123456;
        endcase
    endfunction

    assign bus.pal_rgb = pal_model(bus.pal_index);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [ID_W-1:0] id, input rgb_t rgb, input logic t);
        res_t r;
        r.id     = id;
        r.rgb    = rgb;
        r.transp = t;
        sb_q.push_back(r);
    endtask

    // Check the combinational grant mid-cycle, then move to just after the next edge.
    task automatic step(input logic [N_REQ-1:0] exp_gnt, input string name);
        @(negedge clk_i);
        chk(name, 32'(bus.gnt), 32'(exp_gnt));
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic set_idx(input pal_idx_t i0, input pal_idx_t i1, input pal_idx_t i2, input pal_idx_t i3);
        bus.req_index = {i3, i2, i1, i0};
    endtask

    task automatic reset_dut();
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (sb_q.size() != 0 && cyc < 20) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " out_valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, " pal_index"},  32'(bus.pal_index),  32'd0);
        chk({tag, " out_id"},     32'(bus.out_id),     32'd0);
        chk({tag, " out_rgb"},    32'(bus.out_rgb),    32'd0);
        chk({tag, " out_transp"}, 32'(bus.out_transp), 32'd0);
    endtask

    initial begin
        bus.req       = '0;
        bus.req_index = '0;
        bus.out_ready = 1'b1;

        fork
            forever begin
                @(negedge clk_i);
                if (!rst_i && bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected result: id=%0d rgb=%h transp=%0b, expected none",
                                 bus.out_id, bus.out_rgb, bus.out_transp);
                    end else begin
                        res_t e;
                        res_t a;
                        e = sb_q.pop_front();
                        a.id     = bus.out_id;
                        a.rgb    = bus.out_rgb;
                        a.transp = bus.out_transp;
                        chk("result {id,rgb,transp}", 32'(a), 32'(e));
                    end
                end
            end
        join_none

        // 1: reset state, single request, two-cycle latency
        @(posedge clk_i);
        #1;
        chk_reset_vals("reset");
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        set_idx(8'h02, 8'h00, 8'h00, 8'h00);
        bus.req = 4'b0001;
        push(2'd0, 24'he6e6e6, 1'b0);
        step(4'b0001, "t1 gnt");
        bus.req = 4'b0000;
        chk("t1 valid after edge1", 32'(bus.out_valid), 32'd0);
        step(4'b0000, "t1 no gnt");
        chk("t1 valid after edge2", 32'(bus.out_valid), 32'd1);
        chk("t1 rgb", 32'(bus.out_rgb), 32'h00e6e6e6);
        drain("t1 drained");

        // 2: all four requesting, strict rotation, one result per cycle
        reset_dut();
        set_idx(8'h01, 8'h02, 8'h03, 8'h14);
        bus.req = 4'b1111;
        push(2'd0, 24'h000000, 1'b0);
        push(2'd1, 24'he6e6e6, 1'b0);
        push(2'd2, 24'h505050, 1'b0);
        push(2'd3, 24'h260939, 1'b0);
        push(2'd0, 24'h000000, 1'b0);
        step(4'b0001, "t2 gnt0");
        step(4'b0010, "t2 gnt1");
        step(4'b0100, "t2 gnt2");
        step(4'b1000, "t2 gnt3");
        step(4'b0001, "t2 gnt0 again");
        bus.req = 4'b0000;
        drain("t2 drained");

        // 3: transparent index
        set_idx(8'h01, 8'h02, 8'h00, 8'h14);
        bus.req = 4'b0100;
        push(2'd2, 24'h800080, 1'b1);
        step(4'b0100, "t3 gnt2");
        bus.req = 4'b0000;
        drain("t3 drained");

        // 4: backpressure with both stages full
        idle(2);
        bus.out_ready = 1'b0;
        bus.req       = 4'b1111;
        push(2'd3, 24'h260939, 1'b0);
        push(2'd0, 24'h000000, 1'b0);
        step(4'b1000, "t4 gnt3");
        step(4'b0001, "t4 gnt0");
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, "t4 stall gnt");
            chk("t4 stall valid", 32'(bus.out_valid), 32'd1);
            chk("t4 stall id",    32'(bus.out_id),    32'd3);
            chk("t4 stall rgb",   32'(bus.out_rgb),   32'h00260939);
            chk("t4 stall s1",    32'(bus.pal_index), 32'h00000001);
        end
        bus.out_ready = 1'b1;
        bus.req       = 4'b0010;
        push(2'd1, 24'he6e6e6, 1'b0);
        step(4'b0010, "t4 resume gnt1");
        bus.req = 4'b0000;
        drain("t4 drained");

        // 5: two requesters alternate, pointer wraps from 3
        reset_dut();
        set_idx(8'h01, 8'h02, 8'h00, 8'h14);
        bus.req = 4'b1010;
        push(2'd1, 24'he6e6e6, 1'b0);
        push(2'd3, 24'h260939, 1'b0);
        push(2'd1, 24'he6e6e6, 1'b0);
        push(2'd3, 24'h260939, 1'b0);
        step(4'b0010, "t5 gnt1");
        step(4'b1000, "t5 gnt3");
        step(4'b0010, "t5 gnt1 again");
        step(4'b1000, "t5 gnt3 again");
        bus.req = 4'b0000;
        drain("t5 drained");

        // 6: asynchronous reset with lookups in flight
        set_idx(8'h01, 8'h02, 8'h03, 8'h14);
        bus.req = 4'b1111;
        step(4'b0001, "t6 gnt0");
        step(4'b0010, "t6 gnt1");
        chk("t6 in flight valid", 32'(bus.out_valid), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        chk_reset_vals("t6 async reset");
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        push(2'd0, 24'h000000, 1'b0);
        step(4'b0001, "t6 gnt0 after reset");
        bus.req = 4'b0000;
        drain("t6 drained");
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
